// File: rtl/blackjack_pkg.sv
// Shared constants, FSM state encoding and rank helpers for the blackjack dealer.
// Ranks are numbered 0..12 (ace..king).
package blackjack_pkg;

    localparam int NUM_RANKS = 13;
    localparam int SUITS     = 4;
    localparam int DECK_SIZE = 52;

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        DELAY,
        PRESENT,
        GAP
    } state_t;

    // Ace is 1, pip cards keep their face value, and J/Q/K all count 10.
    function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
        return (rank < 4'd9) ? rank + 4'd1 : 4'd10;
    endfunction

    function automatic logic [3:0] next_rank(input logic [3:0] rank);
        return (rank == 4'(NUM_RANKS - 1)) ? 4'd0 : rank + 4'd1;
    endfunction

endpackage

// File: rtl/blackjack_dealer_lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
// It is reloaded only by reset, so a reshuffle keeps the random sequence going.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] q
);

    localparam logic [15:0] TAPS = 16'hB400;

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= SEED;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/blackjack_dealer.sv
// Dealer side of the card handshake: draws one card per request from a deck held
// as per-rank remaining counts and presents it with a timed card_rdy pulse.
module blackjack_dealer
    import blackjack_pkg::*;
#(
    parameter bit          RANDOM      = 1'b1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int unsigned RDY_DELAY   = 0,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       request_card,
    input  logic       new_game,
    output logic       card_rdy,
    output logic [3:0] card_value,
    output logic       deck_empty,
    output logic [5:0] cards_left
);

    localparam logic [3:0] DELAY_LAST = 4'(RDY_DELAY - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYCLES - 1);

    state_t      state, state_next;
    logic [2:0]  rank_count [NUM_RANKS];
    logic [3:0]  cur_rank;
    logic [3:0]  rank_ptr;
    logic [3:0]  cnt;
    logic [15:0] lfsr_q;
    logic [3:0]  candidate;
    logic        hit;
    logic        lfsr_unused;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clock(clock),
        .reset(reset),
        .q    (lfsr_q)
    );

    // Only the low nibble feeds the rank choice.
    assign lfsr_unused = ^lfsr_q[15:4];

    // Nibble values 13..15 fold back onto ranks 0..2.
    assign candidate = RANDOM ? ((lfsr_q[3:0] >= 4'(NUM_RANKS)) ? lfsr_q[3:0] - 4'(NUM_RANKS)
                                                                : lfsr_q[3:0])
                              : rank_ptr;

    assign hit        = (rank_count[cur_rank] != 3'd0);
    assign deck_empty = (cards_left == 6'd0);

    always_ff @(posedge clock) begin
        if (reset || new_game) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (request_card && !deck_empty) state_next = PICK;
            PICK:    if (hit) state_next = (RDY_DELAY > 0) ? DELAY : PRESENT;
            DELAY:   if (cnt == DELAY_LAST) state_next = PRESENT;
            PRESENT: if (cnt == HOLD_LAST) state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || new_game) begin
            // NOTE: the rank counts are real deck state, so unlike a data buffer
            // this small array is reset; a reshuffle refills every rank at once.
            for (int r = 0; r < NUM_RANKS; r++) begin
                rank_count[r] <= 3'(SUITS);
            end
            cards_left <= 6'(DECK_SIZE);
            card_value <= 4'd0;
            card_rdy   <= 1'b0;
            cur_rank   <= 4'd0;
            rank_ptr   <= 4'd0;
            cnt        <= 4'd0;
        end else begin
            // Registered from the state so card_rdy trails PRESENT by one edge.
            card_rdy <= (state == PRESENT);
            case (state)
                IDLE: begin
                    if (state_next == PICK) cur_rank <= candidate;
                end
                PICK: begin
                    if (hit) begin
                        rank_count[cur_rank] <= rank_count[cur_rank] - 3'd1;
                        cards_left           <= cards_left - 6'd1;
                        card_value           <= rank_to_value(cur_rank);
                        rank_ptr             <= next_rank(rank_ptr);
                        cnt                  <= 4'd0;
                    end else begin
                        cur_rank <= next_rank(cur_rank);
                    end
                end
                DELAY, PRESENT: begin
                    cnt <= (state_next == state) ? cnt + 4'd1 : 4'd0;
                end
                default: ;
            endcase
        end
    end

endmodule
